// File: rtl/instr_byte_fetch_pkg.sv
// Shared constants and types for the instruction byte-fetch front end.
package ifetch_pkg;
    // Matches the rv32i_defs word width used by single_cycle_datapath.
    localparam int InstructionSize = 32;
    localparam int BytesPerInstr = 4;
    localparam int DefaultTimeoutCycles = 255;
    localparam logic [InstructionSize-1:0] INSTR_NOP = 32'h00000013;

    typedef logic [InstructionSize-1:0] instr_word_t;

    typedef enum logic {
        IFETCH_IDLE     = 1'b0,
        IFETCH_ASSEMBLE = 1'b1
    } ifetch_state_e;
endpackage

// File: rtl/instr_byte_fetch_if.sv
// Byte-in / instruction-out handshake bundle between pads, fetch unit and core.
interface instr_byte_fetch_if;
    import ifetch_pkg::*;

    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    instr_word_t instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        input  byte_in, byte_valid, instr_ready,
        output byte_ready, instr, instr_valid
    );

    modport slave (
        output byte_in, byte_valid, instr_ready,
        input  byte_ready, instr, instr_valid
    );
endinterface

// File: rtl/instr_byte_fetch_sync_word_fifo.sv
// Show-ahead synchronous word FIFO with wrap-bit pointers and a flush that empties it.
module sync_word_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // The extra top bit tells full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PtrOne;
            if (do_pop)  rd_ptr <= rd_ptr + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/instr_byte_fetch.sv
// Packs pad bytes into little-endian RV32I words and queues them for the core.
// Optional macro IFETCH_TIMEOUT_EN drops a stalled partial word after TIMEOUT_CYCLES idle cycles.
module instr_byte_fetch
    import ifetch_pkg::*;
#(
    parameter int FIFO_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic                          clk,
    input  logic                          rst_n,
    instr_byte_fetch_if.master            fetch,
    input  logic                          flush,
    output logic [$clog2(BytesPerInstr)-1:0] byte_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam logic [$clog2(BytesPerInstr)-1:0] LastIdx = 2'(BytesPerInstr - 1);

    ifetch_state_e              state;
    logic [InstructionSize-9:0] partial;
    logic                       xfer;
    logic                       last_byte;
    logic                       push;
    logic                       pop;
    logic                       full;
    logic                       empty;
    logic                       timeout;
    instr_word_t                head;

    // Only the last byte of a word needs FIFO room, so earlier bytes are never stalled.
    assign fetch.byte_ready  = !(byte_cnt == LastIdx && full);
    assign xfer              = fetch.byte_valid && fetch.byte_ready;
    assign last_byte         = (state == IFETCH_ASSEMBLE) && (byte_cnt == LastIdx);
    assign push              = xfer && last_byte && !flush;
    assign pop               = fetch.instr_valid && fetch.instr_ready && !flush;
    assign fetch.instr_valid = !empty;
    assign fetch.instr       = empty ? INSTR_NOP : head;

`ifdef IFETCH_TIMEOUT_EN
    logic [7:0] idle_cnt;

    assign timeout = (state == IFETCH_ASSEMBLE) && !xfer && (idle_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (flush || xfer || timeout || state == IFETCH_IDLE) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IFETCH_IDLE;
            byte_cnt <= '0;
            partial  <= '0;
        end else if (flush) begin
            state    <= IFETCH_IDLE;
            byte_cnt <= '0;
        end else if (xfer) begin
            case (byte_cnt)
                2'd0:    partial[7:0]   <= fetch.byte_in;
                2'd1:    partial[15:8]  <= fetch.byte_in;
                2'd2:    partial[23:16] <= fetch.byte_in;
                default: ;
            endcase
            if (last_byte) begin
                state    <= IFETCH_IDLE;
                byte_cnt <= '0;
            end else begin
                state    <= IFETCH_ASSEMBLE;
                byte_cnt <= byte_cnt + 2'd1;
            end
        end else if (timeout) begin
            state    <= IFETCH_IDLE;
            byte_cnt <= '0;
        end
    end

    // The final byte goes straight into the FIFO, so only three bytes are ever held.
    sync_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (InstructionSize)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({fetch.byte_in, partial}),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );
endmodule

// File: doc/instr_byte_fetch.md
Name: instr_byte_fetch

Overview:
Instruction-fetch front end placed directly upstream of single_cycle_datapath.
- Packs the 8-bit pad byte stream (ui_in) into 32-bit RV32I words, little-endian.
- Buffers completed words in a small FIFO and presents the head word to the core's instr input with a valid/ready handshake.
- Drives a NOP to the core whenever no word is available; supports flush on taken branch/jump.

Parameters:
FIFO_DEPTH, 2, number of 32-bit words buffered; power of two, minimum 2.
TIMEOUT_CYCLES, 255, idle cycles before a partial word is discarded (used only with IFETCH_TIMEOUT_EN).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
byte_in  input  8  instruction byte from pads
byte_valid  input  1  byte_in holds a byte this cycle
byte_ready  output  1  block accepts byte_in this cycle
instr  output  32  head instruction word; NOP (32'h00000013) when empty
instr_valid  output  1  instr holds a real fetched word
instr_ready  input  1  core consumes head word this cycle
flush  input  1  drop all buffered and partial words
byte_cnt  output  2  bytes held in the partial-word register
level  output  $clog2(FIFO_DEPTH)+1  words in the FIFO

Behaviour:
- Reset (asynchronous, active-low) clears FIFO pointers, level, byte_cnt, the assembly register and the state machine.
  - Output values in reset: instr_valid=0, instr=NOP, byte_ready=1, byte_cnt=0, level=0.
- Byte transfer occurs on a cycle where byte_valid && byte_ready.
  - Byte k (k = byte_cnt) is written to assembly bits [8k+7:8k]; byte_cnt increments.
- State machine:
  - IDLE: byte_cnt=0.
  - ASSEMBLE: byte_cnt 1..3.
  - IDLE -> ASSEMBLE on a transfer.
  - ASSEMBLE -> IDLE on the 4th byte transfer. The completed word {byte3,byte2,byte1,byte0} is pushed to the FIFO in that cycle and becomes visible on instr on the next cycle (latency 1 cycle from last byte to instr_valid).
- byte_ready = !(byte_cnt==3 && full).
  - Registered state only; no combinational path from instr_ready.
  - The first 3 bytes of a word are always accepted, even when the FIFO is full.
- FIFO is show-ahead.
  - instr = mem[rd_ptr] when level>0, else NOP.
  - instr_valid = (level>0).
  - Pop occurs on instr_valid && instr_ready; instr_ready while empty is ignored.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Pointers carry an extra wrap bit.
  - full = (level==FIFO_DEPTH); empty = (level==0).
  - Pointers wrap modulo FIFO_DEPTH without glitching instr.
- flush has priority over all other events.
  - Next cycle: level=0, byte_cnt=0, state=IDLE, instr=NOP.
  - A byte presented during the flush cycle is accepted (byte_ready unchanged) but discarded.
  - A pop in the flush cycle is a no-op.
- Reset mid-word discards the partial word; no partial word ever reaches the FIFO.
- Stored words are never modified; a word is output exactly once, in arrival order.

Optional Feature:
IFETCH_TIMEOUT_EN
- Defined:
  - An 8-bit idle counter increments each cycle in ASSEMBLE without a transfer; it is cleared on any transfer.
  - On reaching TIMEOUT_CYCLES, byte_cnt returns to 0 and the state to IDLE. The partial word is dropped; FIFO contents are kept.
  - The timeout resynchronises the byte stream after lost bytes. Flush or reset clears the counter.
- Undefined: no counter is instantiated; a partial word is held indefinitely.

Decomposition:
- Package ifetch_pkg:
  - INSTR_NOP = 32'h00000013.
  - BytesPerInstr = 4.
  - State enum {IFETCH_IDLE, IFETCH_ASSEMBLE}.
  - Default TIMEOUT_CYCLES constant.
  - Reuses the rv32i_defs InstructionSize (32) for the word width.
- One sub-module: sync_word_fifo (parameterised depth/width, show-ahead, push/pop/flush, full/empty/level).
- Byte assembly and timeout logic live in the top module.

Test Plan:
- Bytes 93,00,A0,00 with byte_valid=1 back-to-back, instr_ready=0 -> the cycle after byte 4: instr=32'h00A00093, instr_valid=1, level=1.
- FIFO_DEPTH=2 full, stream 3 more bytes then a 4th -> first 3 accepted, byte_ready=0 with byte_cnt=3. One pop -> next cycle byte_ready=1, 4th byte accepted, level returns to 2.
- Level=1, completing a word while instr_ready=1 in the same cycle -> level stays 1; words emerge in arrival order across pointer wrap (10 words streamed).
- Level=2, byte_cnt=2, assert flush with byte_valid=1 -> next cycle level=0, byte_cnt=0, instr=32'h00000013, instr_valid=0.
- rst_n low asynchronously mid-word (byte_cnt=3) -> outputs at reset values immediately, without a clock edge; the next 4 bytes form a clean word.
- IFETCH_TIMEOUT_EN defined, TIMEOUT_CYCLES=8: 2 bytes then 8 idle cycles -> byte_cnt=0; then bytes 13,00,00,00 give instr=32'h00000013, instr_valid=1.
